register64_serial_reader: RTL and testbench

Reads a 64-bit register value and delivers it as a sequence of narrower words over a valid/ready bus. It is the read-side counterpart of the 64-bit storage register: the register's output drives `src_data`, and this block snapshots that value and streams it word by word to a 32-bit consumer (data bus, HI/LO readout path, debug port). Word order is selectable per transfer.

---
 rtl/register64_serial_reader.sv | 119 +++++++++++
 tb/tb_register64_serial_reader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/register64_serial_reader.sv
// Snapshots a wide register value and streams it as BUS_WIDTH words over valid/ready.
// Optional even parity on the output word: define REGISTER64_SERIAL_READER_PARITY_EN.
module register64_serial_reader #(
    parameter int DATA_WIDTH_IN = 64,
    parameter int BUS_WIDTH     = 32,
    parameter int NUM_WORDS     = DATA_WIDTH_IN / BUS_WIDTH
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     hi_first,
    input  logic [DATA_WIDTH_IN-1:0] src_data,
    input  logic                     bus_ready,
    output logic [BUS_WIDTH-1:0]     bus_data,
    output logic                     bus_valid,
    output logic                     bus_parity,
    output logic                     busy,
    output logic                     done
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state, state_n;
    logic [DATA_WIDTH_IN-1:0] snap, snap_n;
    logic [IDX_W-1:0]         idx, idx_n;
    logic                     hi_q, hi_n;
    logic [BUS_WIDTH-1:0]     data_n;
    logic                     last_word;

    function automatic logic [BUS_WIDTH-1:0] word_at(input logic [DATA_WIDTH_IN-1:0] v,
                                                     input logic [IDX_W-1:0] i);
        return v[int'(i)*BUS_WIDTH +: BUS_WIDTH];
    endfunction

    // The counter never wraps: the final word sits at the far end for the chosen direction.
    assign last_word = hi_q ? (idx == '0) : (idx == LAST_IDX);

    always_ff @(negedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        snap_n  = snap;
        idx_n   = idx;
        hi_n    = hi_q;
        data_n  = bus_data;
        case (state)
            IDLE: begin
                if (start) begin
                    snap_n  = src_data;
                    hi_n    = hi_first;
                    idx_n   = hi_first ? LAST_IDX : '0;
                    data_n  = word_at(src_data, idx_n);
                    state_n = SEND;
                end
            end
            SEND: begin
                if (bus_ready) begin
                    if (last_word) begin
                        data_n  = '0;
                        state_n = DONE;
                    end else begin
                        idx_n  = hi_q ? (idx - IDX_W'(1)) : (idx + IDX_W'(1));
                        data_n = word_at(snap, idx_n);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they hold steady for the whole cycle.
    always_ff @(negedge clock) begin
        if (clear) begin
            snap      <= '0;
            idx       <= '0;
            hi_q      <= 1'b0;
            bus_data  <= '0;
            bus_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            snap      <= snap_n;
            idx       <= idx_n;
            hi_q      <= hi_n;
            bus_data  <= data_n;
            bus_valid <= (state_n == SEND);
            busy      <= (state_n == SEND) || (state_n == DONE);
            done      <= (state_n == DONE);
        end
    end

`ifdef REGISTER64_SERIAL_READER_PARITY_EN
    function automatic logic even_parity(input logic [BUS_WIDTH-1:0] w);
        return ^w;
    endfunction

    always_ff @(negedge clock) begin
        if (clear) bus_parity <= 1'b0;
        else       bus_parity <= (state_n == SEND) ? even_parity(data_n) : 1'b0;
    end
`else
    assign bus_parity = 1'b0;
`endif

endmodule

// File: tb/tb_register64_serial_reader.sv
// Directed bench for register64_serial_reader; parity expectations follow
// REGISTER64_SERIAL_READER_PARITY_EN.
module tb_register64_serial_reader;
    logic        clock;
    logic        clear;
    logic        start;
    logic        hi_first;
    logic [63:0] src_data;
    logic        bus_ready;
    logic [31:0] bus_data;
    logic        bus_valid;
    logic        bus_parity;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    register64_serial_reader dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .hi_first  (hi_first),
        .src_data  (src_data),
        .bus_ready (bus_ready),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .bus_parity(bus_parity),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Parity bit the bench expects for a given word; zero when the feature is not built.
    function automatic logic epar(input logic v, input logic [31:0] w);
`ifdef REGISTER64_SERIAL_READER_PARITY_EN
        logic p;
        p = 1'b0;
        for (int i = 0; i < 32; i++) p = p ^ w[i];
        return v ? p : 1'b0;
`else
        return (v && w[0] && 1'b0);
`endif
    endfunction

    task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                              input logic b, input logic dn);
        chk({tag, ".valid"}, 64'(bus_valid), 64'(v));
        if (v) chk({tag, ".data"}, 64'(bus_data), 64'(d));
        chk({tag, ".busy"}, 64'(busy), 64'(b));
        chk({tag, ".done"}, 64'(done), 64'(dn));
        chk({tag, ".parity"}, 64'(bus_parity), 64'(epar(v, d)));
    endtask

    initial begin
        clear     = 1'b1;
        start     = 1'b1;
        hi_first  = 1'b0;
        src_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus_ready = 1'b1;

        // reset held with start asserted
        tick(); expect_out("rst0", 0, 32'h0, 0, 0);
        chk("rst0.data", 64'(bus_data), 64'h0);
        tick(); expect_out("rst1", 0, 32'h0, 0, 0);
        clear = 1'b0; start = 1'b0;
        tick(); expect_out("idle", 0, 32'h0, 0, 0);

        // low-first, ready high
        src_data = 64'h1234_5678_9ABC_DEF0; hi_first = 1'b0; start = 1'b1;
        tick(); expect_out("lo.w0", 1, 32'h9ABC_DEF0, 1, 0);
        start = 1'b0;
        tick(); expect_out("lo.w1", 1, 32'h1234_5678, 1, 0);
        tick(); expect_out("lo.done", 0, 32'h0, 1, 1);
        tick(); expect_out("lo.idle", 0, 32'h0, 0, 0);

        // high-first, backpressure, source changes after capture
        hi_first = 1'b1; start = 1'b1; bus_ready = 1'b0;
        tick(); expect_out("hi.w1a", 1, 32'h1234_5678, 1, 0);
        start = 1'b0; src_data = 64'h0;
        tick(); expect_out("hi.w1b", 1, 32'h1234_5678, 1, 0);
        tick(); expect_out("hi.w1c", 1, 32'h1234_5678, 1, 0);
        tick(); expect_out("hi.w1d", 1, 32'h1234_5678, 1, 0);
        bus_ready = 1'b1;
        tick(); expect_out("hi.w0", 1, 32'h9ABC_DEF0, 1, 0);
        tick(); expect_out("hi.done", 0, 32'h0, 1, 1);
        tick(); expect_out("hi.idle", 0, 32'h0, 0, 0);

        // clear after the first word is accepted
        src_data = 64'h1234_5678_9ABC_DEF0; hi_first = 1'b0; start = 1'b1;
        tick(); expect_out("ab.w0", 1, 32'h9ABC_DEF0, 1, 0);
        start = 1'b0;
        tick(); expect_out("ab.w1", 1, 32'h1234_5678, 1, 0);
        clear = 1'b1;
        tick(); expect_out("ab.clr", 0, 32'h0, 0, 0);
        chk("ab.clr.data", 64'(bus_data), 64'h0);
        clear = 1'b0;
        tick(); expect_out("ab.nodone", 0, 32'h0, 0, 0);
        start = 1'b1;
        tick(); expect_out("ab.r.w0", 1, 32'h9ABC_DEF0, 1, 0);
        start = 1'b0;
        tick(); expect_out("ab.r.w1", 1, 32'h1234_5678, 1, 0);
        tick(); expect_out("ab.r.done", 0, 32'h0, 1, 1);
        tick(); expect_out("ab.r.idle", 0, 32'h0, 0, 0);

        // start held high through a whole transfer
        src_data = 64'hCAFE_F00D_0BAD_BEEF; start = 1'b1;
        tick(); expect_out("hold.w0", 1, 32'h0BAD_BEEF, 1, 0);
        tick(); expect_out("hold.w1", 1, 32'hCAFE_F00D, 1, 0);
        tick(); expect_out("hold.done", 0, 32'h0, 1, 1);
        tick(); expect_out("hold.idle", 0, 32'h0, 0, 0);
        tick(); expect_out("hold.2.w0", 1, 32'h0BAD_BEEF, 1, 0);
        start = 1'b0;
        tick(); expect_out("hold.2.w1", 1, 32'hCAFE_F00D, 1, 0);
        tick(); expect_out("hold.2.done", 0, 32'h0, 1, 1);
        tick(); expect_out("hold.2.idle", 0, 32'h0, 0, 0);

        // parity vectors with hand-computed bits
        src_data = 64'h0000_0001_0000_0003; start = 1'b1;
        tick(); expect_out("par.w0", 1, 32'h0000_0003, 1, 0);
        chk("par.w0.bit", 64'(bus_parity), 64'h0);
        start = 1'b0;
        tick(); expect_out("par.w1", 1, 32'h0000_0001, 1, 0);
`ifdef REGISTER64_SERIAL_READER_PARITY_EN
        chk("par.w1.bit", 64'(bus_parity), 64'h1);
`else
        chk("par.w1.bit", 64'(bus_parity), 64'h0);
`endif
        tick(); expect_out("par.done", 0, 32'h0, 1, 1);
        tick(); expect_out("par.idle", 0, 32'h0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
